// File: rtl/fxp_vec_div.sv
// ============================================================================
// Module  : fxp_vec_div
// Brief   : Lane-parallel signed fixed-point divider, q = (a << WORD_LEN) / b,
//           by 2*WORD_LEN restoring steps per lane, then round/sign/saturate.
//           Optional macro FXP_DIV_ROUND_EN: round half away from zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef MATRIX_DIM
`define MATRIX_DIM 8
`endif

module fxp_vec_div #(
  parameter int WORD_LEN   = `WORD_LEN,
  parameter int MATRIX_DIM = `MATRIX_DIM,
  parameter int W          = WORD_LEN * MATRIX_DIM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          dividend,
  input  logic [W-1:0]          divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          quotient,
  output logic [MATRIX_DIM-1:0] dz_flag
);

  localparam int NUM_W = 2 * WORD_LEN;
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(NUM_W - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [WORD_LEN-1:0] MAX_POS  = {1'b0, {(WORD_LEN-1){1'b1}}};
  localparam logic [WORD_LEN-1:0] MIN_NEG  = {1'b1, {(WORD_LEN-1){1'b0}}};
  localparam logic [NUM_W-1:0]    POS_LIM  = {{WORD_LEN{1'b0}}, MAX_POS};
  localparam logic [NUM_W-1:0]    NEG_LIM  = {{WORD_LEN{1'b0}}, MIN_NEG};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [W-1:0]            quotient_q, quotient_d;
  logic [MATRIX_DIM-1:0]   dz_flag_q, dz_flag_d;

  logic [NUM_W-1:0]        num_q  [MATRIX_DIM];
  logic [NUM_W-1:0]        num_d  [MATRIX_DIM];
  logic [NUM_W-1:0]        quo_q  [MATRIX_DIM];
  logic [NUM_W-1:0]        quo_d  [MATRIX_DIM];
  logic [WORD_LEN:0]       rem_q  [MATRIX_DIM];
  logic [WORD_LEN:0]       rem_d  [MATRIX_DIM];
  logic [WORD_LEN-1:0]     bmag_q [MATRIX_DIM];
  logic [WORD_LEN-1:0]     bmag_d [MATRIX_DIM];
  logic [MATRIX_DIM-1:0]   sgn_q, sgn_d, dz_q, dz_d, aneg_q, aneg_d;

  logic [WORD_LEN-1:0]     a_l, b_l, amag, res;
  logic [WORD_LEN:0]       rem_sh;
  logic [NUM_W-1:0]        mag;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign dz_flag   = dz_flag_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    dz_flag_d   = dz_flag_q;
    num_d       = num_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    bmag_d      = bmag_q;
    sgn_d       = sgn_q;
    dz_d        = dz_q;
    aneg_d      = aneg_q;
    a_l         = '0;
    b_l         = '0;
    amag        = '0;
    res         = '0;
    rem_sh      = '0;
    mag         = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < MATRIX_DIM; i++) begin
            a_l       = dividend[i*WORD_LEN +: WORD_LEN];
            b_l       = divisor[i*WORD_LEN +: WORD_LEN];
            // Two's-complement negate of the most negative value yields 2^(N-1) unsigned.
            amag      = a_l[WORD_LEN-1] ? -a_l : a_l;
            num_d[i]  = {amag, {WORD_LEN{1'b0}}};
            bmag_d[i] = b_l[WORD_LEN-1] ? -b_l : b_l;
            sgn_d[i]  = a_l[WORD_LEN-1] ^ b_l[WORD_LEN-1];
            dz_d[i]   = (b_l == '0);
            aneg_d[i] = a_l[WORD_LEN-1];
            rem_d[i]  = '0;
            quo_d[i]  = '0;
          end
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        for (int i = 0; i < MATRIX_DIM; i++) begin
          rem_sh   = (rem_q[i] << 1) | {{WORD_LEN{1'b0}}, num_q[i][NUM_W-1]};
          num_d[i] = num_q[i] << 1;
          if (rem_sh >= {1'b0, bmag_q[i]}) begin
            rem_d[i] = rem_sh - {1'b0, bmag_q[i]};
            quo_d[i] = {quo_q[i][NUM_W-2:0], 1'b1};
          end else begin
            rem_d[i] = rem_sh;
            quo_d[i] = {quo_q[i][NUM_W-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        for (int i = 0; i < MATRIX_DIM; i++) begin
          mag = quo_q[i];
`ifdef FXP_DIV_ROUND_EN
          if ({rem_q[i][WORD_LEN-1:0], 1'b0} >= {1'b0, bmag_q[i]}) begin
            mag = mag + {{(NUM_W-1){1'b0}}, 1'b1};
          end
`endif
          if (dz_q[i]) begin
            res = aneg_q[i] ? MIN_NEG : MAX_POS;
          end else if (sgn_q[i] && (mag != '0)) begin
            res = (mag > NEG_LIM) ? MIN_NEG : -mag[WORD_LEN-1:0];
          end else begin
            res = (mag > POS_LIM) ? MAX_POS : mag[WORD_LEN-1:0];
          end
          quotient_d[i*WORD_LEN +: WORD_LEN] = res;
        end
        dz_flag_d   = dz_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      dz_flag_q   <= '0;
      sgn_q       <= '0;
      dz_q        <= '0;
      aneg_q      <= '0;
      for (int i = 0; i < MATRIX_DIM; i++) begin
        num_q[i]  <= '0;
        quo_q[i]  <= '0;
        rem_q[i]  <= '0;
        bmag_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      dz_flag_q   <= dz_flag_d;
      sgn_q       <= sgn_d;
      dz_q        <= dz_d;
      aneg_q      <= aneg_d;
      for (int i = 0; i < MATRIX_DIM; i++) begin
        num_q[i]  <= num_d[i];
        quo_q[i]  <= quo_d[i];
        rem_q[i]  <= rem_d[i];
        bmag_q[i] <= bmag_d[i];
      end
    end
  end

endmodule

`default_nettype wire
